// File: rtl/alu_sequencer.sv
// alu_sequencer: buffers ALU commands in a small FIFO, issues them one at a time
// to a combinational 16-bit ALU, captures the result and returns it over a
// valid/ready response port. Keeps a 17-bit accumulator of the last good result
// and a saturating count of errored commands.
module alu_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic        cmd_use_acc,
  input  logic [15:0] cmd_x,
  input  logic [15:0] cmd_y,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic [2:0]  alu_op,
  input  logic [16:0] alu_out,
  input  logic        alu_err,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [16:0] rsp_data,
  output logic        rsp_err,
  output logic [16:0] acc,
  output logic [7:0]  err_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] SettleLoad = CW'(SETTLE - 1);
  localparam logic [AW:0]   DepthCount = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StRespond} state_e;

  // Command storage, one array per field
  logic [2:0]  fifo_op     [DEPTH];
  logic        fifo_use_acc[DEPTH];
  logic [15:0] fifo_x      [DEPTH];
  logic [15:0] fifo_y      [DEPTH];

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  state_e        state_q;
  logic [CW-1:0] settle_q;

  logic full, empty, push, pop;

  // Handshake decode; cmd_ready is forced low while reset is held
  always_comb begin
    full      = (count_q == DepthCount);
    empty     = (count_q == '0);
    cmd_ready = reset && !full;
    push      = cmd_valid && cmd_ready;
    pop       = (state_q == StIdle) && !empty;
  end

  // FIFO payload write; contents need no reset since count gates every read
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_op[wr_ptr_q]      <= cmd_op;
      fifo_use_acc[wr_ptr_q] <= cmd_use_acc;
      fifo_x[wr_ptr_q]       <= cmd_x;
      fifo_y[wr_ptr_q]       <= cmd_y;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth wraps naturally
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end

  // Issue FSM with all ALU-side and response-side outputs registered
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      settle_q  <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      alu_op    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      acc       <= '0;
      err_count <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            alu_op   <= fifo_op[rd_ptr_q];
            alu_y    <= fifo_y[rd_ptr_q];
            // acc[16] is dropped when the accumulator feeds the ALU
            alu_x    <= fifo_use_acc[rd_ptr_q] ? acc[15:0] : fifo_x[rd_ptr_q];
            settle_q <= SettleLoad;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (settle_q == '0) begin
            rsp_data  <= alu_out;
            rsp_err   <= alu_err;
            if (!alu_err) begin
              acc <= alu_out;
            end else if (err_count != 8'hFF) begin
              err_count <= err_count + 8'd1;
            end
            rsp_valid <= 1'b1;
            state_q   <= StRespond;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        StRespond: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven initiator for the 16-bit ALU. It buffers operation requests in a small FIFO and issues each one to the combinational ALU (`alu_x`/`alu_y`/`alu_op` out, `alu_out`/`alu_err` back). It captures the result and error flag, then returns them over a valid/ready response port. It also keeps a 17-bit accumulator so that commands can be chained on the previous good result. It sits between the test/control logic and `ALU16bit`, and replaces ad-hoc per-cycle op driving.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `SETTLE`, 1: cycles ALU inputs are held before the result is sampled (≥1).
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: FIFO can accept.
- `cmd_op` in 3: ALU op code (0 add, 1 sub, 2 shl, 3 shr, 4 AND, 5 OR, 6 XOR, 7 NOT).
- `cmd_use_acc` in 1: when 1, x operand = `acc[15:0]` instead of `cmd_x`.
- `cmd_x`, `cmd_y` in 16 each: operands.
- `alu_x`, `alu_y` out 16 each: registered operands to ALU.
- `alu_op` out 3: registered op to ALU.
- `alu_out` in 17: ALU result.
- `alu_err` in 1: ALU overflow/underflow flag.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes result.
- `rsp_data` out 17: captured `alu_out`.
- `rsp_err` out 1: captured `alu_err`.
- `acc` out 17: last error-free result.
- `err_count` out 8: saturating count of errored commands.

## Operation
- FIFO: push on `cmd_valid && cmd_ready`. `cmd_ready = !full`, and is 0 in any cycle where `reset` is low. There is no push-when-full bypass, even if a pop happens in the same cycle. Each entry stores {op, use_acc, x, y}. Pointers wrap modulo `DEPTH`.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head and register `alu_op`, `alu_y`, and `alu_x` (`acc[15:0]` sampled at the pop edge if use_acc, else x). Go to ISSUE. Load settle counter = `SETTLE`-1.
  - ISSUE: hold the ALU inputs and decrement the counter. When the counter is 0:
    - `rsp_data <= alu_out`, `rsp_err <= alu_err`.
    - If `alu_err` = 0: `acc <= alu_out`.
    - Else: `acc` is unchanged and `err_count` increments, saturating at 255.
    - Go to RESPOND.
  - RESPOND: `rsp_valid` = 1, with `rsp_data`/`rsp_err`/`alu_*` stable. On `rsp_ready`, go to IDLE; `rsp_valid` is low the next cycle.
- A use_acc command sees the accumulator as updated by every previously completed command, since only one command is in flight.
- `acc[16]` (sign/extension bit) is retained in `acc` and dropped when `acc` is used as an operand.
- The FIFO may accept new commands in any state, including RESPOND while stalled.

## Timing
- Reset values: `cmd_ready` 0 during reset and 1 the first cycle after release. `alu_x`, `alu_y`, `alu_op`, `rsp_valid`, `rsp_data`, `rsp_err`, `acc`, and `err_count` are all 0. FIFO is empty and the FSM is in IDLE.
- Latency: a command accepted in cycle N into an empty FIFO while in IDLE is popped at the end of N+1. The ALU inputs are valid in cycles N+2 … N+1+`SETTLE`. `rsp_valid` rises in cycle N+2+`SETTLE` (N+3 at default).
- Minimum spacing between responses with `rsp_ready` tied high: `SETTLE`+2 cycles.
- Reset asserted mid-operation (any state) clears the FIFO, FSM, accumulator, counter, and all outputs at that edge. `rsp_valid` is low the next cycle and no partial response is produced.
- All outputs are registered except `cmd_ready`, which is combinational from the FIFO count and `reset`.

## Test plan
- Basic add: bench instantiates the real ALU; send op 0, x=0x00E1, y=0x0B01 with `rsp_ready` high → `rsp_valid` at accept+3, `rsp_data`=0x00BE2, `rsp_err`=0, `acc`=0x00BE2.
- Overflow: op 0, x=0x0001, y=0xFFFF → `rsp_data`=0, `rsp_err`=1. `acc` keeps its prior value, `err_count` goes 0→1.
- Chaining: add 0x0003+0x0004, then op 2 with use_acc=1, then op 3 with use_acc=1 → responses 0x0007, 0x000E, 0x0007, with final `acc`=0x0007.
- Backpressure/full: hold `rsp_ready` low and push 6 commands back-to-back.
  - `cmd_ready` falls after the FIFO holds `DEPTH` entries; the first command is in RESPOND, so 5 are accepted in total.
  - Release `rsp_ready` → all 5 responses come out in order with no loss or duplication, and `rsp_data` is stable while stalled.
- Reset mid-flight: with 3 commands queued and one in ISSUE, drive `reset` low for 1 cycle → next cycle `rsp_valid`=0, `cmd_ready`=1, `acc`=0, and no stale responses afterwards.
- Error saturation: issue 260 overflowing adds → `err_count` = 255 and holds.
